// File: rtl/path_trace32_if.sv
// Bundles the memory read channel and the coordinate output stream of path_trace32.
// master = the path tracer; slave = the memory and the consumer side.
interface path_trace32_if;
  logic        txn_req;
  logic        txn_wr;
  logic [31:0] txn_addr;
  logic [31:0] txn_wdata;
  logic        txn_rdy;
  logic [31:0] txn_rdata;
  logic        path_valid;
  logic        path_ready;
  logic [4:0]  path_x;
  logic [4:0]  path_y;
  logic        path_last;

  modport master (
    output txn_req, txn_wr, txn_addr, txn_wdata,
    input  txn_rdy, txn_rdata,
    output path_valid, path_x, path_y, path_last,
    input  path_ready
  );

  modport slave (
    input  txn_req, txn_wr, txn_addr, txn_wdata,
    output txn_rdy, txn_rdata,
    input  path_valid, path_x, path_y, path_last,
    output path_ready
  );
endinterface

// File: rtl/path_trace32.sv
// Walks parent pointers in the 32x32 direction map from a goal node back to the
// start node, streaming each visited coordinate and pulsing int_done at the end.
module path_trace32 #(
  parameter logic [31:0] ADDR_DIR = 32'h4000_2000,
  parameter int          MAX_LEN  = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        ctrl_wr,
  input  logic [31:0] ctrl_in,
  output logic [31:0] ctrl_out,
  output logic        int_done,
  path_trace32_if.master bus
);

  // DONE and ERR complete in a single cycle, so they are folded into the
  // transitions back to IDLE rather than held as states of their own.
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RD_WAIT, S_DECODE, S_EMIT
  } state_t;

  localparam logic [10:0] LEN_LAST = 11'(MAX_LEN - 1);

  state_t      state_q, state_d;
  logic [4:0]  cur_x, cur_y, goal_x, goal_y;
  logic [2:0]  dir_q;
  logic [10:0] len_q;
  logic        done_q, err_q;
  logic [31:0] cache_word;
  logic [6:0]  cache_tag;
  logic        cache_valid;

  logic [9:0]  cur_n;
  logic [3:0]  nibble;
  logic        cache_hit, bad_dir;
  logic        go_acc, fill, emit_hs, fin_ok, fin_err;

  assign cur_n     = {cur_y, cur_x};
  assign nibble    = cache_word[{cur_n[2:0], 2'b00} +: 4];
  assign cache_hit = cache_valid && (cache_tag == cur_n[9:3]);

  // Only the low three bits of a nibble carry a direction.
  logic unused_bits;
  assign unused_bits = ^{ctrl_in[30:10], nibble[3]};

  // A code is rejected if it is undefined or would step off the grid edge.
  always_comb begin
    bad_dir = 1'b0;
    case (nibble[2:0])
      3'd0:    bad_dir = 1'b0;
      3'd1:    bad_dir = (cur_x == 5'd31);
      3'd2:    bad_dir = (cur_x == 5'd0);
      3'd3:    bad_dir = (cur_y == 5'd31);
      3'd4:    bad_dir = (cur_y == 5'd0);
      default: bad_dir = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    go_acc  = 1'b0;
    fill    = 1'b0;
    emit_hs = 1'b0;
    fin_ok  = 1'b0;
    fin_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl_wr && ctrl_in[31]) begin
          go_acc  = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: state_d = cache_hit ? S_DECODE : S_RD_WAIT;
      S_RD_WAIT: begin
        if (bus.txn_rdy) begin
          fill    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (bad_dir) begin
          fin_err = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (bus.path_ready) begin
          emit_hs = 1'b1;
          if (dir_q == 3'd0) begin
            fin_ok  = 1'b1;
            state_d = S_IDLE;
          end else if (len_q == LEN_LAST) begin
            fin_err = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOOKUP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cur_x       <= '0;
      cur_y       <= '0;
      goal_x      <= '0;
      goal_y      <= '0;
      dir_q       <= '0;
      len_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cache_tag   <= '0;
      cache_valid <= 1'b0;
      int_done    <= 1'b0;
    end else begin
      int_done <= fin_ok | fin_err;
      if (go_acc) begin
        goal_x      <= ctrl_in[4:0];
        goal_y      <= ctrl_in[9:5];
        cur_x       <= ctrl_in[4:0];
        cur_y       <= ctrl_in[9:5];
        len_q       <= '0;
        done_q      <= 1'b0;
        err_q       <= 1'b0;
        cache_valid <= 1'b0;
      end
      if (fill) begin
        cache_valid <= 1'b1;
        cache_tag   <= cur_n[9:3];
      end
      if (state_q == S_DECODE) dir_q <= nibble[2:0];
      if (emit_hs) begin
        len_q <= len_q + 11'd1;
        if (!fin_ok && !fin_err) begin
          case (dir_q)
            3'd1:    cur_x <= cur_x + 5'd1;
            3'd2:    cur_x <= cur_x - 5'd1;
            3'd3:    cur_y <= cur_y + 5'd1;
            default: cur_y <= cur_y - 5'd1;
          endcase
        end
      end
      if (fin_ok || fin_err) done_q <= 1'b1;
      if (fin_err)           err_q  <= 1'b1;
    end
  end

  // NOTE: the cached data word needs no reset; cache_valid alone decides
  // whether its contents may be used.
  always_ff @(posedge clk) begin
    if (fill) cache_word <= bus.txn_rdata;
  end

  assign bus.txn_req    = (state_q == S_LOOKUP) && !cache_hit;
  assign bus.txn_wr     = 1'b0;
  assign bus.txn_wdata  = '0;
  assign bus.txn_addr   = bus.txn_req ? (ADDR_DIR + {23'd0, cur_n[9:3], 2'b00}) : '0;
  assign bus.path_valid = (state_q == S_EMIT);
  assign bus.path_x     = cur_x;
  assign bus.path_y     = cur_y;
  assign bus.path_last  = (state_q == S_EMIT) && (dir_q == 3'd0);

  assign ctrl_out = {(state_q != S_IDLE), done_q, err_q, 2'b00, len_q,
                     6'd0, goal_y, goal_x};

endmodule

// File: tb/tb_path_trace32.sv
// Self-checking bench for path_trace32: a walk-level reference model predicts
// the reads, the record stream and the final status for each map and goal.
module tb_path_trace32;
  localparam logic [31:0] ADDR_DIR = 32'h4000_2000;
  localparam int          MAX_LEN  = 1024;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic       last;
  } rec_t;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        ctrl_wr = 1'b0;
  logic [31:0] ctrl_in = '0;
  logic [31:0] ctrl_out;
  logic        int_done;

  path_trace32_if bus();

  path_trace32 dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .ctrl_wr  (ctrl_wr),
    .ctrl_in  (ctrl_in),
    .ctrl_out (ctrl_out),
    .int_done (int_done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] dmem [128];
  rec_t        exp_rec [$];
  logic [31:0] exp_rd  [$];
  logic [31:0] exp_ctrl;
  bit          exp_end_on_hs;

  int   errors = 0, checks = 0;
  int   cycle = 0, int_cnt = 0, last_hs_cycle = 0;
  int   rd_lat = 1, rdy_mode = 0;
  bit   mon_en = 1'b0, outstanding = 1'b0, prev_stall = 1'b0;
  rec_t prev_rec;
  logic [31:0] rsp_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Consumer: 0 always ready, 1 toggling, 2 random, 3 never ready.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.path_ready = 1'b1;
      1:       bus.path_ready = ~bus.path_ready;
      3:       bus.path_ready = 1'b0;
      default: bus.path_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Memory: answers a request seen in cycle t with rdy during cycle t+rd_lat.
  always begin
    @(negedge clk);
    if (bus.txn_req) begin
      rsp_addr = bus.txn_addr;
      repeat (rd_lat) @(posedge clk);
      #1;
      bus.txn_rdy   = 1'b1;
      bus.txn_rdata = dmem[rsp_addr[8:2]];
      @(posedge clk);
      #1;
      bus.txn_rdy   = 1'b0;
      bus.txn_rdata = $urandom;
    end
  end

  // Compare process: reads, records, stall stability and the done pulse.
  always @(negedge clk) begin
    cycle++;
    if (int_done) int_cnt++;
    if (mon_en) begin
      if (bus.txn_req) begin
        check("read_single_outstanding", 32'(outstanding), 32'd0);
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got addr %h, no read expected", bus.txn_addr);
        end else begin
          check("read_addr", bus.txn_addr, exp_rd.pop_front());
        end
        outstanding = 1'b1;
      end
      if (bus.txn_rdy) outstanding = 1'b0;
      if (prev_stall)
        check("stall_hold", {21'd0, bus.path_valid, bus.path_x, bus.path_y, bus.path_last},
              {21'd0, 1'b1, prev_rec});
      if (bus.path_valid && bus.path_ready) begin
        if (exp_rec.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_record: got (%0d,%0d,last=%0d), none expected",
                   bus.path_x, bus.path_y, bus.path_last);
        end else begin
          check("record", {21'd0, bus.path_x, bus.path_y, bus.path_last},
                {21'd0, exp_rec.pop_front()});
        end
        last_hs_cycle = cycle;
      end
      prev_stall = bus.path_valid && !bus.path_ready;
      prev_rec   = {bus.path_x, bus.path_y, bus.path_last};
      if (int_done) begin
        check("done_busy_flags", 32'(ctrl_out[31:30]), 32'd1);
        if (exp_end_on_hs) check("done_latency", 32'(cycle - last_hs_cycle), 32'd1);
      end
    end
  end

  task automatic set_code(input int x, input int y, input int c);
    int n;
    logic [31:0] wv;
    n  = x + 32 * y;
    wv = dmem[n / 8];
    wv[4 * (n % 8) +: 4] = 4'(c);
    dmem[n / 8] = wv;
  endtask

  // Reference model: follow parent pointers with plain integer coordinates.
  task automatic build_expect(input logic [4:0] gx, input logic [4:0] gy);
    int x, y, cached, len, n, w, code;
    bit err, fin;
    x = int'(gx); y = int'(gy); cached = -1; len = 0; err = 0; fin = 0;
    exp_rec.delete();
    exp_rd.delete();
    exp_end_on_hs = 0;
    while (!fin) begin
      n = x + 32 * y;
      w = n / 8;
      if (w != cached) begin
        exp_rd.push_back(ADDR_DIR + 32'(w * 4));
        cached = w;
      end
      code = int'((dmem[w] >> (4 * (n % 8))) & 32'd7);
      if (code >= 5 || (code == 1 && x == 31) || (code == 2 && x == 0) ||
          (code == 3 && y == 31) || (code == 4 && y == 0)) begin
        err = 1; fin = 1;
      end else begin
        exp_rec.push_back({5'(x), 5'(y), code == 0});
        len++;
        if (code == 0) begin
          fin = 1; exp_end_on_hs = 1;
        end else if (len == MAX_LEN) begin
          err = 1; fin = 1; exp_end_on_hs = 1;
        end else begin
          case (code)
            1:       x++;
            2:       x--;
            3:       y++;
            default: y--;
          endcase
        end
      end
    end
    exp_ctrl = {1'b0, 1'b1, err, 2'b00, 11'(len), 6'd0, gy, gx};
  endtask

  task automatic start_go(input logic [4:0] gx, input logic [4:0] gy);
    @(posedge clk);
    #1;
    ctrl_in = {1'b1, 21'd0, gy, gx};
    ctrl_wr = 1'b1;
    @(posedge clk);
    #1;
    ctrl_wr = 1'b0;
    ctrl_in = '0;
    @(negedge clk);
    check("go_busy", 32'(ctrl_out[31]), 32'd1);
    check("go_first_req", 32'(bus.txn_req), 32'd1);
  endtask

  task automatic run_walk(input logic [4:0] gx, input logic [4:0] gy,
                          input int mode, input int lat, input bit inject);
    int start_cnt, i;
    rd_lat = lat; rdy_mode = mode; start_cnt = int_cnt;
    outstanding = 0; prev_stall = 0; mon_en = 1;
    start_go(gx, gy);
    if (inject) begin
      repeat (4) @(posedge clk);
      #1;
      ctrl_in = 32'h8000_03FF;
      ctrl_wr = 1'b1;
      @(posedge clk);
      #1;
      ctrl_wr = 1'b0;
      ctrl_in = '0;
    end
    i = 0;
    while (i < 20000 && int_cnt == start_cnt) begin
      @(posedge clk);
      i++;
    end
    if (int_cnt == start_cnt) begin
      checks++; errors++;
      $display("FAIL walk_timeout: got no int_done within 20000 cycles, goal (%0d,%0d)", gx, gy);
    end
    repeat (3) @(negedge clk);
    check("records_left", 32'(exp_rec.size()), 32'd0);
    check("reads_left", 32'(exp_rd.size()), 32'd0);
    check("ctrl_out_final", ctrl_out, exp_ctrl);
    check("int_done_count", 32'(int_cnt - start_cnt), 32'd1);
    check("valid_after", 32'(bus.path_valid), 32'd0);
    mon_en = 0;
  endtask

  task automatic load_straight();
    for (int i = 0; i < 128; i++) dmem[i] = 32'h7777_7777;
    dmem[0] = 32'h2222_2000;
    dmem[1] = 32'h7777_7722;
  endtask

  task automatic gen_random(output logic [4:0] gx, output logic [4:0] gy);
    bit vis [1024];
    int x, y, steps, c, nx, ny;
    bit moved;
    for (int i = 0; i < 128; i++) dmem[i] = $urandom;
    for (int i = 0; i < 1024; i++) vis[i] = 0;
    x = $urandom_range(0, 31);
    y = $urandom_range(0, 31);
    vis[x + 32 * y] = 1;
    set_code(x, y, 0);
    steps = $urandom_range(3, 40);
    for (int k = 0; k < steps; k++) begin
      moved = 0;
      for (int t = 0; t < 8 && !moved; t++) begin
        c = $urandom_range(1, 4);
        nx = x; ny = y;
        case (c)
          1:       nx = x - 1;
          2:       nx = x + 1;
          3:       ny = y - 1;
          default: ny = y + 1;
        endcase
        if (nx >= 0 && nx < 32 && ny >= 0 && ny < 32 && !vis[nx + 32 * ny]) begin
          vis[nx + 32 * ny] = 1;
          set_code(nx, ny, c);
          x = nx; y = ny; moved = 1;
        end
      end
    end
    gx = 5'(x); gy = 5'(y);
  endtask

  initial begin
    logic [4:0] gx, gy;
    int i;
    bus.txn_rdy = 1'b0;
    bus.txn_rdata = '0;
    bus.path_ready = 1'b0;
    for (int k = 0; k < 128; k++) dmem[k] = '0;

    repeat (3) @(negedge clk);
    check("rst_ctrl_out", ctrl_out, 32'd0);
    check("rst_outputs", {27'd0, bus.txn_req, bus.path_valid, bus.path_last, int_done, bus.txn_wr},
          32'd0);
    check("rst_addr", bus.txn_addr, 32'd0);
    @(posedge clk);
    #1 arst_n = 1'b1;

    // Goal equals start.
    dmem[12] = 32'h0000_0000;
    build_expect(5'd5, 5'd3);
    check("pin_model_addr", exp_rd[0], 32'h4000_2030);
    check("pin_model_nrec", 32'(exp_rec.size()), 32'd1);
    run_walk(5'd5, 5'd3, 0, 1, 0);
    check("pin_ctrl_single", ctrl_out, 32'h4001_0065);

    // Straight path from (9,0) to (2,0).
    load_straight();
    build_expect(5'd9, 5'd0);
    check("pin_model_len8", 32'(exp_rec.size()), 32'd8);
    check("pin_model_rd1", exp_rd[1], 32'h4000_2000);
    run_walk(5'd9, 5'd0, 0, 1, 0);
    check("pin_ctrl_straight", ctrl_out, 32'h4008_0009);

    // Same path, toggling ready, slow memory, and a go written while busy.
    build_expect(5'd9, 5'd0);
    run_walk(5'd9, 5'd0, 1, 3, 1);

    // Off-grid step from the corner.
    dmem[127] = 32'h1000_0000;
    build_expect(5'd31, 5'd31);
    check("pin_model_err_nrec", 32'(exp_rec.size()), 32'd0);
    run_walk(5'd31, 5'd31, 0, 2, 0);
    check("pin_ctrl_corner", ctrl_out, 32'h6000_03FF);

    // Two-node loop runs into the length limit.
    dmem[17] = 32'h0000_2100;
    build_expect(5'd10, 5'd4);
    check("pin_model_loop_len", 32'(exp_rec.size()), 32'd1024);
    run_walk(5'd10, 5'd4, 2, 2, 0);
    check("pin_ctrl_loop", ctrl_out, 32'h6400_008A);

    // Reset while a read is outstanding; the late rdy must be ignored.
    load_straight();
    rd_lat = 6; rdy_mode = 0; mon_en = 0;
    start_go(5'd9, 5'd0);
    i = 0;
    while (i < 50 && !bus.txn_req) begin @(negedge clk); i++; end
    @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    check("rst_rdwait_ctrl", ctrl_out, 32'd0);
    check("rst_rdwait_req", 32'(bus.txn_req), 32'd0);
    @(posedge clk);
    #1 arst_n = 1'b1;
    i = int_cnt;
    repeat (12) @(negedge clk);
    check("late_rdy_ctrl", ctrl_out, 32'd0);
    check("late_rdy_quiet", {30'd0, bus.txn_req, bus.path_valid}, 32'd0);
    check("late_rdy_no_irq", 32'(int_cnt - i), 32'd0);

    // Reset while a record is stalled drops path_valid at once.
    rd_lat = 1; rdy_mode = 3;
    start_go(5'd9, 5'd0);
    i = 0;
    while (i < 50 && !bus.path_valid) begin @(negedge clk); i++; end
    check("stall_valid_seen", 32'(bus.path_valid), 32'd1);
    #2 arst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(bus.path_valid), 32'd0);
    @(posedge clk);
    #1 arst_n = 1'b1;
    repeat (2) @(negedge clk);

    // A fresh go after reset completes normally.
    build_expect(5'd9, 5'd0);
    run_walk(5'd9, 5'd0, 0, 1, 0);

    // Random paths under random latency and back-pressure.
    for (int r = 0; r < 6; r++) begin
      gen_random(gx, gy);
      build_expect(gx, gy);
      run_walk(gx, gy, $urandom_range(0, 2), $urandom_range(1, 4), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
